// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//   Multi-cycle divider for the RV32M DIV/DIVU/REM/REMU operations. A restoring
//   shift-subtract loop retires one quotient bit per clock, so an ordinary
//   operation finishes N+1 cycles after it is accepted. Divide-by-zero and the
//   signed overflow case (most-negative / -1) skip the loop and finish one
//   cycle after acceptance.
//
// Ports
//   clk    : single clock, all state updates on its rising edge
//   rst    : asynchronous, active-low reset
//   start  : request a new operation (only looked at while idle)
//   op     : 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   a      : dividend (rs1), captured on the accepting edge
//   b      : divisor  (rs2), captured on the accepting edge
//   busy   : high while an accepted operation has not completed
//   done   : one-cycle registered pulse, result valid
//   result : last completed result, held until the next completion
// -----------------------------------------------------------------------------
module seq_divider #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [N-1:0] ONE     = N'(1);
  localparam logic [N-1:0] MOST_NEG = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] ALL_ONES = {N{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    CALC   = 2'b01,
    FINISH = 2'b10
  } state_t;

  state_t state_q;
  state_t state_d;

  // Operation context latched at acceptance
  logic          rem_sel_q;
  logic          special_q;
  logic          q_neg_q;
  logic          r_neg_q;
  logic [CW-1:0] cnt_q;

  // dvd_q starts as the dividend magnitude and shifts quotient bits in from the
  // right; for special cases it simply carries the precomputed answer.
  logic [N-1:0]  dvd_q;
  logic [N-1:0]  dvs_q;
  logic [N-1:0]  rem_q;

  // Acceptance-time decode
  logic          op_signed;
  logic          div_by_zero;
  logic          overflow;
  logic          is_special;
  logic [N-1:0]  special_val;
  logic [N-1:0]  abs_a;
  logic [N-1:0]  abs_b;

  // One restoring step
  logic [N:0]    shifted;
  logic [N:0]    trial;
  logic          q_bit;
  logic          last_step;

  // Finish-time sign correction
  logic [N-1:0]  quo_fix;
  logic [N-1:0]  rem_fix;

  assign op_signed   = ~op[0];
  assign div_by_zero = (b == '0);
  assign overflow    = op_signed && (a == MOST_NEG) && (b == ALL_ONES);
  assign is_special  = div_by_zero || overflow;

  // Divide-by-zero: quotient all ones, remainder is the dividend.
  // Overflow: quotient is the dividend itself (most negative), remainder zero.
  assign special_val = div_by_zero ? (op[1] ? a : ALL_ONES)
                                   : (op[1] ? '0 : MOST_NEG);

  assign abs_a = (op_signed && a[N-1]) ? (~a + ONE) : a;
  assign abs_b = (op_signed && b[N-1]) ? (~b + ONE) : b;

  // The partial remainder is always below the divisor, so the shifted value
  // fits in N+1 bits and the sign of the trial subtraction is its top bit.
  assign shifted   = {rem_q, dvd_q[N-1]};
  assign trial     = shifted - {1'b0, dvs_q};
  assign q_bit     = ~trial[N];
  assign last_step = (cnt_q == CW'(N - 1));

  assign quo_fix = q_neg_q ? (~dvd_q + ONE) : dvd_q;
  assign rem_fix = r_neg_q ? (~rem_q + ONE) : rem_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = is_special ? FINISH : CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC:    state_d = last_step ? FINISH : CALC;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_sel_q <= 1'b0;
      special_q <= 1'b0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      cnt_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            rem_sel_q <= op[1];
            special_q <= is_special;
            q_neg_q   <= op_signed & (a[N-1] ^ b[N-1]);
            r_neg_q   <= op_signed & a[N-1];
            cnt_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= abs_b;
            dvd_q     <= is_special ? special_val : abs_a;
            busy      <= 1'b1;
          end
        end
        CALC: begin
          rem_q <= q_bit ? trial[N-1:0] : shifted[N-1:0];
          dvd_q <= {dvd_q[N-2:0], q_bit};
          cnt_q <= cnt_q + 1'b1;
        end
        FINISH: begin
          if (special_q) begin
            result <= dvd_q;
          end else begin
            result <= rem_sel_q ? rem_fix : quo_fix;
          end
          busy <= 1'b0;
          done <= 1'b1;
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_res = '0;

  seq_divider #(.N(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model straight from the RV32M rules, using native signed and
  // unsigned arithmetic (SV integer division truncates toward zero and the
  // remainder follows the dividend's sign).
  function automatic logic [31:0] refResult(input logic [1:0] o, input logic [31:0] x,
                                            input logic [31:0] y);
    int sx;
    int sy;
    sx = x;
    sy = y;
    if (y == 32'd0) return o[1] ? x : 32'hFFFF_FFFF;
    if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
      return o[1] ? 32'd0 : 32'h8000_0000;
    case (o)
      OP_DIV:  return 32'(sx / sy);
      OP_DIVU: return x / y;
      OP_REM:  return 32'(sx % sy);
      default: return x % y;
    endcase
  endfunction

  function automatic int refLatency(input logic [1:0] o, input logic [31:0] x,
                                    input logic [31:0] y);
    if (y == 32'd0) return 1;
    if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one request starting at the current (negedge-aligned) time; returns
  // at the negedge after the accepting edge with inputs scrambled, so any
  // late operand change would corrupt a design that failed to latch them.
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkEq("busy_after_accept", {31'd0, busy}, 32'd1);
    checkEq("done_is_pulse", {31'd0, done}, 32'd0);
    checkEq("result_held", result, last_res);
    op = 2'($urandom);
    a  = $urandom;
    b  = $urandom;
  endtask

  // Waits (bounded) for done, pulsing start randomly while busy; returns at
  // the negedge where done is seen, with start low.
  task automatic checkOutput(input logic [31:0] exp_res, input int exp_lat);
    int cycles;
    bit seen;
    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles < 40) begin
      @(negedge clk);
      cycles++;
      if (done === 1'b1) begin
        seen = 1'b1;
      end else begin
        checkEq("busy_while_running", {31'd0, busy}, 32'd1);
        start = 1'($urandom);
        op    = 2'($urandom);
        a     = $urandom;
        b     = $urandom;
      end
    end
    start = 1'b0;
    checkEq("done_seen", {31'd0, seen}, 32'd1);
    checkEq("latency", 32'(cycles), 32'(exp_lat));
    checkEq("busy_low_with_done", {31'd0, busy}, 32'd0);
    checkEq("result", result, exp_res);
    last_res = exp_res;
  endtask

  task automatic runOp(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    applyStimulus(o, x, y);
    checkOutput(refResult(o, x, y), refLatency(o, x, y));
  endtask

  task automatic idleGap();
    @(negedge clk);
    checkEq("idle_busy_low", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    int          sel;

    rst   = 1'b0;
    start = 1'b0;
    op    = '0;
    a     = '0;
    b     = '0;
    $display("[TB] starting seq_divider bench");

    repeat (2) @(negedge clk);
    checkEq("reset_busy", {31'd0, busy}, 32'd0);
    checkEq("reset_done", {31'd0, done}, 32'd0);
    checkEq("reset_result", result, 32'd0);

    // Release and issue on the very first rising edge
    rst = 1'b1;
    runOp(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    checkEq("div_m7_by_2", result, 32'hFFFF_FFFD);
    idleGap();
    runOp(OP_REM, 32'hFFFF_FFF9, 32'd2);
    checkEq("rem_m7_by_2", result, 32'hFFFF_FFFF);

    idleGap();
    runOp(OP_DIVU, 32'hFFFF_FFFF, 32'd0);
    idleGap();
    runOp(OP_REMU, 32'd5, 32'd0);
    checkEq("remu_by_zero", result, 32'd5);
    idleGap();
    runOp(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    checkEq("div_overflow", result, 32'h8000_0000);
    idleGap();
    runOp(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF);
    checkEq("rem_overflow", result, 32'd0);

    // Back-to-back: second request issued in the done cycle
    idleGap();
    runOp(OP_DIVU, 32'd100, 32'd7);
    checkEq("divu_100_7", result, 32'd14);
    runOp(OP_REMU, 32'd100, 32'd7);
    checkEq("remu_100_7", result, 32'd2);
    runOp(OP_DIVU, 32'd7, 32'd0);

    // Reset in the middle of a calculation
    idleGap();
    applyStimulus(OP_DIV, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    checkEq("abort_busy", {31'd0, busy}, 32'd0);
    checkEq("abort_result", result, 32'd0);
    last_res = '0;
    repeat (3) begin
      @(negedge clk);
      checkEq("abort_no_done", {31'd0, done}, 32'd0);
    end
    rst = 1'b1;
    runOp(OP_DIV, 32'd9, 32'd3);
    checkEq("div_9_3_after_reset", result, 32'd3);

    // Randomised operations against the reference model
    for (int i = 0; i < 40; i++) begin
      ro  = 2'($urandom);
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 7);
      case (sel)
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = $urandom_range(1, 15);
        3: rb = 32'hFFFF_FFFF;
        4: ra = $urandom_range(0, 50);
        default: ;
      endcase
      if ($urandom_range(0, 1) == 1) idleGap();
      runOp(ro, ra, rb);
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
